data_demux_pp: RTL and testbench

DATA_DEMUX_PP -- requirements
Module: data_demux_pp

---
 rtl/data_demux_pp.sv | 232 +++++++++++++++++++++++
 tb/tb_data_demux_pp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_demux_pp.sv
// rtl/data_demux_pp.sv - serial frame receiver with ping-pong banks and zero-skipping channel demux
module data_demux_pp #(
    parameter int                WORD_W       = 10,
    parameter int                DATA_W       = 8,
    parameter int                FRAME_WORDS  = 90,
    parameter int                NUM_CH       = 3,
    parameter int                SYNC_W       = 10,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = '1
) (
    input  logic                     CLK_30MHZ,
    input  logic                     RST,
    input  logic                     DIN,
    input  logic [1:0]               MODE,
    output logic [NUM_CH*DATA_W-1:0] DOUT,
    output logic [NUM_CH-1:0]        DOUT_VALID,
    output logic                     SYNC_LOCK,
    output logic                     FRAME_DONE,
    output logic                     SYNC_ERR
);

    localparam int IDX_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int BIT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int HUNT_LIMIT = 4 * FRAME_WORDS * WORD_W;
    localparam int HC_W       = $clog2(HUNT_LIMIT + 1);
    localparam int CH_W       = 2;

    typedef enum logic {HUNT = 1'b0, RECV = 1'b1} rx_state_t;
    typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_t;

    // receive side state
    rx_state_t         rx_state, rx_state_next;
    logic [SYNC_W-2:0] hunt_sr, hunt_sr_next;   // the SYNC_W-1 bits preceding the current DIN
    logic [WORD_W-2:0] word_sr, word_sr_next;   // partial word collected so far
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
    logic [IDX_W-1:0]  word_idx, word_idx_next;
    logic              wr_bank, wr_bank_next;
    logic [HC_W-1:0]   hunt_cnt, hunt_cnt_next;
    logic              sync_err, sync_err_next;
    logic              sync_lock;
    logic [SYNC_W-1:0] sync_window;
    logic [WORD_W-1:0] wr_word;
    logic              wr_en;
    logic              bank_filled;

    // readout side state
    rd_state_t                rd_state, rd_state_next;
    logic                     rd_bank, rd_bank_next;
    logic [IDX_W-1:0]         rd_idx, rd_idx_next;
    logic [1:0]               mode_lat, mode_lat_next;
    logic [CH_W-1:0]          ch_ptr, ch_ptr_next;
    logic [1:0]               full, full_next;
    logic [NUM_CH*DATA_W-1:0] dout, dout_next;
    logic [NUM_CH-1:0]        dout_valid, dout_valid_next;
    logic                     frame_done, frame_done_next;
    logic [DATA_W-1:0]        payload;
    logic [IDX_W-1:0]         start_idx, last_idx;
    logic [CH_W-1:0]          ptr_last;

    logic [WORD_W-1:0] bank_mem [2][FRAME_WORDS];

    assign sync_window = {hunt_sr, DIN};
    assign wr_word     = {word_sr, DIN};

    // receive FSM: hunt for the sync marker, then assemble MSB-first words into the active bank
    always_comb begin
        rx_state_next = rx_state;
        hunt_sr_next  = hunt_sr;
        word_sr_next  = word_sr;
        bit_cnt_next  = bit_cnt;
        word_idx_next = word_idx;
        wr_bank_next  = wr_bank;
        hunt_cnt_next = hunt_cnt;
        sync_err_next = sync_err;
        wr_en         = 1'b0;
        bank_filled   = 1'b0;
        case (rx_state)
            HUNT: begin
                hunt_sr_next = sync_window[SYNC_W-2:0];
                if (sync_window == SYNC_PATTERN) begin
                    rx_state_next = RECV;
                    hunt_sr_next  = '0;
                    word_sr_next  = '0;
                    bit_cnt_next  = '0;
                    word_idx_next = '0;
                    hunt_cnt_next = '0;
                end else begin
                    if (hunt_cnt != HC_W'(HUNT_LIMIT))
                        hunt_cnt_next = hunt_cnt + 1'b1;
                    if (hunt_cnt_next == HC_W'(HUNT_LIMIT))
                        sync_err_next = 1'b1;
                end
            end
            RECV: begin
                word_sr_next = wr_word[WORD_W-2:0];
                if (bit_cnt == BIT_W'(WORD_W - 1)) begin
                    bit_cnt_next = '0;
                    wr_en        = 1'b1;
                    if (word_idx == IDX_W'(FRAME_WORDS - 1)) begin
                        word_idx_next = '0;
                        bank_filled   = 1'b1;
                        wr_bank_next  = ~wr_bank;
                        rx_state_next = HUNT;
                    end else begin
                        word_idx_next = word_idx + 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            default: rx_state_next = HUNT;
        endcase
    end

    // receive side registers; SYNC_LOCK follows the state the FSM is entering
    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST) begin
            rx_state  <= HUNT;
            hunt_sr   <= '0;
            word_sr   <= '0;
            bit_cnt   <= '0;
            word_idx  <= '0;
            wr_bank   <= 1'b0;
            hunt_cnt  <= '0;
            sync_err  <= 1'b0;
            sync_lock <= 1'b0;
        end else begin
            rx_state  <= rx_state_next;
            hunt_sr   <= hunt_sr_next;
            word_sr   <= word_sr_next;
            bit_cnt   <= bit_cnt_next;
            word_idx  <= word_idx_next;
            wr_bank   <= wr_bank_next;
            hunt_cnt  <= hunt_cnt_next;
            sync_err  <= sync_err_next;
            sync_lock <= (rx_state_next == RECV);
        end
    end

    // frame storage; contents are meaningless until a bank is marked full, so no reset
    always_ff @(posedge CLK_30MHZ) begin
        if (wr_en)
            bank_mem[wr_bank][word_idx] <= wr_word;
    end

    assign payload   = bank_mem[rd_bank][rd_idx][WORD_W-1 -: DATA_W];
    assign start_idx = MODE[0] ? IDX_W'(FRAME_WORDS - 1) : '0;
    assign last_idx  = mode_lat[0] ? '0 : IDX_W'(FRAME_WORDS - 1);
    assign ptr_last  = mode_lat[1] ? CH_W'(NUM_CH - 1) : CH_W'(1);

    // readout FSM: walk a full bank one word per cycle, dealing nonzero payloads round-robin
    always_comb begin
        rd_state_next   = rd_state;
        rd_bank_next    = rd_bank;
        rd_idx_next     = rd_idx;
        mode_lat_next   = mode_lat;
        ch_ptr_next     = ch_ptr;
        full_next       = full;
        dout_next       = dout;
        dout_valid_next = '0;
        frame_done_next = 1'b0;
        if (bank_filled)
            full_next[wr_bank] = 1'b1;
        case (rd_state)
            IDLE: begin
                if (full[rd_bank]) begin
                    rd_state_next = READ;
                    mode_lat_next = MODE;
                    rd_idx_next   = start_idx;
                    ch_ptr_next   = '0;
                end
            end
            READ: begin
                if (payload != '0) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (CH_W'(c) == ch_ptr) begin
                            dout_next[c*DATA_W +: DATA_W] = payload;
                            dout_valid_next[c]            = 1'b1;
                        end
                    end
                    ch_ptr_next = (ch_ptr == ptr_last) ? '0 : ch_ptr + 1'b1;
                end
                if (rd_idx == last_idx) begin
                    frame_done_next    = 1'b1;
                    full_next[rd_bank] = 1'b0;
                    rd_bank_next       = ~rd_bank;
                    if (full[~rd_bank]) begin
                        mode_lat_next = MODE;
                        rd_idx_next   = start_idx;
                        ch_ptr_next   = '0;
                    end else begin
                        rd_state_next = IDLE;
                    end
                end else begin
                    rd_idx_next = mode_lat[0] ? rd_idx - 1'b1 : rd_idx + 1'b1;
                end
            end
            default: rd_state_next = IDLE;
        endcase
    end

    // readout side registers and output drivers
    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST) begin
            rd_state   <= IDLE;
            rd_bank    <= 1'b0;
            rd_idx     <= '0;
            mode_lat   <= '0;
            ch_ptr     <= '0;
            full       <= '0;
            dout       <= '0;
            dout_valid <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_state   <= rd_state_next;
            rd_bank    <= rd_bank_next;
            rd_idx     <= rd_idx_next;
            mode_lat   <= mode_lat_next;
            ch_ptr     <= ch_ptr_next;
            full       <= full_next;
            dout       <= dout_next;
            dout_valid <= dout_valid_next;
            frame_done <= frame_done_next;
        end
    end

    assign DOUT       = dout;
    assign DOUT_VALID = dout_valid;
    assign SYNC_LOCK  = sync_lock;
    assign FRAME_DONE = frame_done;
    assign SYNC_ERR   = sync_err;

endmodule

// File: tb/tb_data_demux_pp.sv
// tb/tb_data_demux_pp.sv - directed table-driven bench for data_demux_pp
module tb_data_demux_pp;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;
    localparam int FW     = 90;
    localparam int NUM_CH = 3;
    localparam int SYNC_W = 10;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     din   = 1'b0;
    logic [1:0]               mode  = 2'b00;
    logic [NUM_CH*DATA_W-1:0] dout;
    logic [NUM_CH-1:0]        dout_valid;
    logic                     sync_lock;
    logic                     frame_done;
    logic                     sync_err;

    data_demux_pp dut (
        .CLK_30MHZ  (clk),
        .RST        (rst_n),
        .DIN        (din),
        .MODE       (mode),
        .DOUT       (dout),
        .DOUT_VALID (dout_valid),
        .SYNC_LOCK  (sync_lock),
        .FRAME_DONE (frame_done),
        .SYNC_ERR   (sync_err)
    );

    always #16 clk = ~clk;

    typedef struct {
        int ch;
        int val;
    } strobe_t;

    typedef struct {
        logic [1:0] mode;
        int         kind;
        int         exp_strobes;
        int         first_ch;
        int         first_val;
        int         last_ch;
        int         last_val;
        int         ch2_cnt;
        int         first_lat;
        int         fd_lat;
    } vec_t;

    strobe_t          got_q[$];
    strobe_t          exp_q[$];
    logic [DATA_W-1:0] pl [FW];
    int               mdl_dout [NUM_CH];
    int               checks    = 0;
    int               errors    = 0;
    int               fd_cnt    = 0;
    int               multi_hot = 0;

    // capture every strobe and frame_done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            int n;
            n = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (dout_valid[c]) begin
                    strobe_t s;
                    s.ch  = c;
                    s.val = int'(dout[c*DATA_W +: DATA_W]);
                    got_q.push_back(s);
                    n++;
                end
            end
            if (n > 1) multi_hot++;
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        #(34 * 60000);
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        @(negedge clk);
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < FW; i++) begin
            pl[i] = DATA_W'(i + 1);
            if (kind == 1 && (i == 0 || i == 5 || i == FW - 1)) pl[i] = '0;
        end
    endtask

    task automatic build_expected(input logic [1:0] m);
        int ptr;
        int n;
        int idx;
        ptr = 0;
        n   = m[1] ? NUM_CH : 2;
        for (int k = 0; k < FW; k++) begin
            idx = m[0] ? FW - 1 - k : k;
            if (pl[idx] != 0) begin
                strobe_t s;
                s.ch  = ptr;
                s.val = int'(pl[idx]);
                exp_q.push_back(s);
                ptr = (ptr + 1) % n;
            end
        end
    endtask

    task automatic send_frame(input int nwords, input int sw_bit, input logic [1:0] sw_mode);
        int bitn;
        logic [WORD_W-1:0] word;
        bitn = 0;
        for (int i = 0; i < SYNC_W; i++) send_bit(1'b1);
        chk("sync_lock_after_sync", sync_lock, 1);
        for (int w = 0; w < nwords; w++) begin
            word = {pl[w], ~w[1:0]};
            for (int b = WORD_W - 1; b >= 0; b--) begin
                if (bitn == sw_bit) mode = sw_mode;
                send_bit(word[b]);
                bitn++;
            end
        end
        if (nwords == FW) chk("sync_lock_after_frame", sync_lock, 0);
        din = 1'b0;
    endtask

    task automatic wait_frame(output int first_lat, output int fd_lat);
        int cyc;
        first_lat = -1;
        fd_lat    = -1;
        cyc       = 0;
        while (cyc < 400 && fd_lat < 0) begin
            @(negedge clk);
            cyc++;
            if (dout_valid != '0 && first_lat < 0) first_lat = cyc;
            if (frame_done) fd_lat = cyc;
        end
        chk("frame_done_seen", (fd_lat >= 0), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic compare_seq(input string tag);
        int bad;
        int first_bad;
        bad       = 0;
        first_bad = -1;
        chk($sformatf("%s_strobe_count", tag), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i].ch != exp_q[i].ch || got_q[i].val != exp_q[i].val) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        if (bad != 0)
            $display("  %s first bad strobe %0d: got ch%0d=%0d expected ch%0d=%0d", tag, first_bad,
                     got_q[first_bad].ch, got_q[first_bad].val, exp_q[first_bad].ch, exp_q[first_bad].val);
        chk($sformatf("%s_seq_mismatches", tag), bad, 0);
    endtask

    task automatic check_hold(input string tag);
        foreach (exp_q[i]) mdl_dout[exp_q[i].ch] = exp_q[i].val;
        for (int c = 0; c < NUM_CH; c++)
            chk($sformatf("%s_dout_ch%0d", tag, c), dout[c*DATA_W +: DATA_W], mdl_dout[c]);
    endtask

    task automatic run_frame(input string tag, input logic [1:0] m, input int kind,
                             output int first_lat, output int fd_lat);
        fill(kind);
        mode = m;
        got_q.delete();
        exp_q.delete();
        build_expected(m);
        send_frame(FW, -1, 2'b00);
        wait_frame(first_lat, fd_lat);
        compare_seq(tag);
        check_hold(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        din   = 1'b0;
        #1;
        chk($sformatf("%s_outputs_zero", tag), {dout, dout_valid, sync_lock, frame_done, sync_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        got_q.delete();
        for (int c = 0; c < NUM_CH; c++) mdl_dout[c] = 0;
    endtask

    initial begin
        vec_t vecs[6];
        int   fl;
        int   fdl;
        int   n2;
        int   fd_base;

        //          mode   kind strobes fch fval lch lval ch2 flat fdlat
        vecs[0] = '{2'b00, 0,   90,     0,  1,   1,  90,  0,  2,   91};
        vecs[1] = '{2'b11, 0,   90,     0,  90,  2,  1,   30, 2,   91};
        vecs[2] = '{2'b01, 0,   90,     0,  90,  1,  1,   0,  2,   91};
        vecs[3] = '{2'b10, 0,   90,     0,  1,   2,  90,  30, 2,   91};
        vecs[4] = '{2'b00, 1,   87,     0,  2,   0,  89,  0,  3,   91};
        vecs[5] = '{2'b11, 1,   87,     0,  89,  2,  2,   29, 3,   91};

        for (int c = 0; c < NUM_CH; c++) mdl_dout[c] = 0;

        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 0);
        chk("reset_dout_valid", dout_valid, 0);
        chk("reset_sync_lock", sync_lock, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_sync_err", sync_err, 0);
        rst_n = 1'b1;
        repeat (4) send_bit(1'b0);

        for (int r = 0; r < 6; r++) begin
            run_frame($sformatf("row%0d", r), vecs[r].mode, vecs[r].kind, fl, fdl);
            chk($sformatf("row%0d_first_latency", r), fl, vecs[r].first_lat);
            chk($sformatf("row%0d_done_latency", r), fdl, vecs[r].fd_lat);
            chk($sformatf("row%0d_table_strobes", r), got_q.size(), vecs[r].exp_strobes);
            chk($sformatf("row%0d_first_ch", r), got_q[0].ch, vecs[r].first_ch);
            chk($sformatf("row%0d_first_val", r), got_q[0].val, vecs[r].first_val);
            chk($sformatf("row%0d_last_ch", r), got_q[got_q.size()-1].ch, vecs[r].last_ch);
            chk($sformatf("row%0d_last_val", r), got_q[got_q.size()-1].val, vecs[r].last_val);
            n2 = 0;
            foreach (got_q[i]) if (got_q[i].ch == 2) n2++;
            chk($sformatf("row%0d_ch2_strobes", r), n2, vecs[r].ch2_cnt);
        end

        // back-to-back frames; MODE flips to 3 while the first frame is still being read out
        fill(0);
        mode = 2'b00;
        got_q.delete();
        exp_q.delete();
        build_expected(2'b00);
        build_expected(2'b11);
        fd_base = fd_cnt;
        send_frame(FW, -1, 2'b00);
        send_frame(FW, 40, 2'b11);
        wait_frame(fl, fdl);
        chk("b2b_frame_done_count", fd_cnt - fd_base, 2);
        compare_seq("b2b");
        check_hold("b2b");

        // hunt timeout sets a sticky error
        do_reset("reset_before_hunt");
        for (int i = 0; i < 4 * FW * WORD_W - 1; i++) send_bit(1'b0);
        chk("sync_err_before_limit", sync_err, 0);
        send_bit(1'b0);
        chk("sync_err_at_limit", sync_err, 1);
        run_frame("after_err", 2'b00, 0, fl, fdl);
        chk("sync_err_sticky", sync_err, 1);

        // reset in the middle of a frame being received
        fill(0);
        send_frame(40, -1, 2'b00);
        chk("lock_mid_recv", sync_lock, 1);
        do_reset("reset_mid_recv");
        @(negedge clk);
        chk("mid_recv_no_strobe", dout_valid, 0);
        chk("mid_recv_lock_low", sync_lock, 0);
        run_frame("rehunt", 2'b10, 0, fl, fdl);

        // reset in the middle of a readout
        fill(0);
        mode = 2'b00;
        send_frame(FW, -1, 2'b00);
        repeat (20) @(negedge clk);
        fd_base = fd_cnt;
        do_reset("reset_mid_read");
        @(negedge clk);
        chk("mid_read_no_strobe", dout_valid, 0);
        repeat (150) @(negedge clk);
        chk("mid_read_no_more_strobes", got_q.size(), 0);
        chk("mid_read_no_frame_done", fd_cnt - fd_base, 0);

        chk("onehot_violations", multi_hot, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
